// File: rtl/bias_fetch_ctrl_pkg.sv
// rtl/bias_fetch_ctrl_pkg.sv - shared state encoding and DDR constants for bias_fetch_ctrl
// Contents: controller state enum, DDR read command code, beat-size helper and
// the beat byte count for the default 512-bit DDR interface.
package bias_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bfc_state_e;

  localparam logic [2:0] DDR_CMD_READ = 3'b001;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int DDR_BEAT_BYTES = beat_bytes(512);

endpackage

// File: rtl/bias_fetch_ctrl_fifo.sv
// rtl/bias_fetch_ctrl_fifo.sv - beat FIFO holding DDR read beats awaiting unpack
// Ports: clk, rst_n (sync active-low), i_clr (sync flush), i_push/i_data (write side),
// i_pop (read side, head shown on o_data), o_count (current occupancy).
module sync_beat_fifo #(
  parameter  int WIDTH = 512,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A push at full is dropped unless a pop frees the slot in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bias_fetch_ctrl.sv
// rtl/bias_fetch_ctrl.sv - fetches bias entries from DDR and writes them into the bias buffer
// Ports: clk, rst_n (sync active-low); bfc_* command inputs and bfc_idle status;
// app_* DDR read command/return interface; bb_wr_* bias-buffer write port.
module bias_fetch_ctrl
  import bias_fetch_ctrl_pkg::*;
#(
  parameter int X_PE            = 16,
  parameter int ADDR_LEN_BB     = 7,
  parameter int SINGLE_LEN      = 24,
  parameter int DDR_ADDR_LEN    = 32,
  parameter int DDR_DATA_W      = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bfc_conf,
  input  logic [SINGLE_LEN-1:0]   bfc_bias_num,
  input  logic [SINGLE_LEN-1:0]   bfc_bias_ddr_byte,
  input  logic [DDR_ADDR_LEN-1:0] bfc_ddr_st_addr,
  input  logic [ADDR_LEN_BB-1:0]  bfc_bb_st_addr,
  output logic                    bfc_idle,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [DDR_ADDR_LEN-1:0] app_addr,
  input  logic                    app_rdy,
  input  logic [DDR_DATA_W-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  output logic                    bb_wr_en,
  output logic [ADDR_LEN_BB-1:0]  bb_wr_addr,
  output logic [X_PE*8-1:0]       bb_wr_data
);

  localparam int BEAT_BYTES = beat_bytes(DDR_DATA_W);
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int ENT_W      = X_PE * 8;
  localparam int ENTRIES    = DDR_DATA_W / ENT_W;
  localparam int EIDX_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int BC_W       = SINGLE_LEN + 1;

  bfc_state_e              r_state;
  bfc_state_e              w_next_state;
  logic [SINGLE_LEN-1:0]   r_num;
  logic [BC_W-1:0]         r_beats;
  logic [BC_W-1:0]         r_issued;
  logic [BC_W-1:0]         r_popped;
  logic [SINGLE_LEN-1:0]   r_written;
  logic [DDR_ADDR_LEN-1:0] r_app_addr;
  logic [ADDR_LEN_BB-1:0]  r_bb_addr;
  logic [DDR_DATA_W-1:0]   r_beat;
  logic                    r_unpacking;
  logic [EIDX_W-1:0]       r_eidx;

  logic [BC_W-1:0]         w_beats_calc;
  logic                    w_app_en;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_wr_en;
  logic                    w_last_wr;
  logic [ENT_W-1:0]        w_wr_data;
  logic [DDR_DATA_W-1:0]   w_fifo_head;
  logic [CNT_W-1:0]        w_fifo_count;

  assign w_beats_calc = ({1'b0, bfc_bias_ddr_byte} + BC_W'(BEAT_BYTES - 1)) >> BEAT_SHIFT;

  // Credit: beats issued but not yet popped never exceed FIFO depth, so returns always fit.
  assign w_app_en = (r_state == ST_RUN) && (r_num != '0) && (r_issued < r_beats) &&
                    ((r_issued - r_popped) < BC_W'(MAX_OUTSTANDING));

  // Returns outside RUN belong to abandoned or finished jobs and are dropped.
  assign w_push = app_rd_data_valid && (r_state == ST_RUN);

  sync_beat_fifo #(
    .WIDTH (DDR_DATA_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_beat_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state != ST_RUN),
    .i_push  (w_push),
    .i_data  (app_rd_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  // Entry 0 of a beat is written straight from the FIFO head in the pop cycle;
  // the rest come from the latched copy.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_data    = '0;
    if (r_state == ST_RUN && r_written != r_num) begin
      if (r_unpacking) begin
        w_wr_en   = 1'b1;
        w_wr_data = r_beat[int'(r_eidx)*ENT_W +: ENT_W];
      end else if (w_fifo_count != '0) begin
        w_pop     = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_data = w_fifo_head[ENT_W-1:0];
      end
    end
    w_last_wr = w_wr_en && ((r_written + SINGLE_LEN'(1)) == r_num);
    case (r_state)
      ST_IDLE: if (bfc_conf) w_next_state = ST_RUN;
      ST_RUN:  if (r_num == '0 || w_last_wr) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_num       <= '0;
      r_beats     <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_written   <= '0;
      r_app_addr  <= '0;
      r_bb_addr   <= '0;
      r_beat      <= '0;
      r_unpacking <= 1'b0;
      r_eidx      <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && bfc_conf) begin
        r_num       <= bfc_bias_num;
        r_beats     <= w_beats_calc;
        r_issued    <= '0;
        r_popped    <= '0;
        r_written   <= '0;
        r_app_addr  <= bfc_ddr_st_addr & ~DDR_ADDR_LEN'(BEAT_BYTES - 1);
        r_bb_addr   <= bfc_bb_st_addr;
        r_unpacking <= 1'b0;
        r_eidx      <= '0;
      end else begin
        if (w_app_en && app_rdy) begin
          r_issued   <= r_issued + BC_W'(1);
          r_app_addr <= r_app_addr + DDR_ADDR_LEN'(BEAT_BYTES);
        end
        if (w_pop) begin
          r_popped <= r_popped + BC_W'(1);
          r_beat   <= w_fifo_head;
        end
        if (w_wr_en) begin
          r_written <= r_written + SINGLE_LEN'(1);
          r_bb_addr <= r_bb_addr + ADDR_LEN_BB'(1);
          if (w_pop) begin
            if (ENTRIES > 1 && !w_last_wr) begin
              r_unpacking <= 1'b1;
              r_eidx      <= EIDX_W'(1);
            end
          end else if (r_eidx == EIDX_W'(ENTRIES - 1) || w_last_wr) begin
            r_unpacking <= 1'b0;
            r_eidx      <= '0;
          end else begin
            r_eidx <= r_eidx + EIDX_W'(1);
          end
        end
        if (r_state != ST_RUN) begin
          r_unpacking <= 1'b0;
          r_eidx      <= '0;
        end
      end
    end
  end

  assign bfc_idle   = (r_state == ST_IDLE);
  assign app_en     = w_app_en;
  assign app_cmd    = DDR_CMD_READ;
  assign app_addr   = r_app_addr;
  assign bb_wr_en   = w_wr_en;
  assign bb_wr_addr = r_bb_addr;
  assign bb_wr_data = w_wr_data;

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// tb/tb_bias_fetch_ctrl.sv - randomized self-checking bench for bias_fetch_ctrl
module tb_bias_fetch_ctrl;

  logic         clk;
  logic         rst_n;
  logic         bfc_conf;
  logic [23:0]  bfc_bias_num;
  logic [23:0]  bfc_bias_ddr_byte;
  logic [31:0]  bfc_ddr_st_addr;
  logic [6:0]   bfc_bb_st_addr;
  logic         bfc_idle;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [31:0]  app_addr;
  logic         app_rdy;
  logic [511:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         bb_wr_en;
  logic [6:0]   bb_wr_addr;
  logic [127:0] bb_wr_data;

  bias_fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bfc_conf          (bfc_conf),
    .bfc_bias_num      (bfc_bias_num),
    .bfc_bias_ddr_byte (bfc_bias_ddr_byte),
    .bfc_ddr_st_addr   (bfc_ddr_st_addr),
    .bfc_bb_st_addr    (bfc_bb_st_addr),
    .bfc_idle          (bfc_idle),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_rdy           (app_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .bb_wr_en          (bb_wr_en),
    .bb_wr_addr        (bb_wr_addr),
    .bb_wr_data        (bb_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_pct = 100;
  int lat     = 2;
  int n_acc   = 0;
  int n_wr    = 0;
  logic [31:0] data_seed = 32'h0;

  logic [31:0]  exp_cmd[$];
  logic [6:0]   exp_wa[$];
  logic [127:0] exp_wd[$];
  logic [31:0]  obs_cmd[$];
  logic [6:0]   obs_wa[$];
  logic [127:0] obs_wd[$];
  logic [31:0]  resp_addr[$];
  int           resp_due[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Memory content: each 32-bit word of a beat is its address mixed with a word index.
  function automatic logic [511:0] beat_data(input logic [31:0] a);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = a ^ (32'(j) * 32'h01010101) ^ data_seed;
    return r;
  endfunction

  // DDR responder: random ready, in-order returns after the job's latency.
  initial begin
    app_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      app_rdy = ($urandom_range(99) < rdy_pct);
      if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = beat_data(resp_addr.pop_front());
        void'(resp_due.pop_front());
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
      end
    end
  end

  // Compare process against the expected command and write lists.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_cmd.size() == 0) chk("app_en_no_beats_left", app_en, 0);
      else if (app_en) begin
        chk("app_cmd", app_cmd, 3'b001);
        chk("outstanding_limit", (n_acc - (n_wr + 3) / 4) < 4, 1);
        if (app_rdy) begin
          chk("app_addr", app_addr, exp_cmd[0]);
          obs_cmd.push_back(app_addr);
          resp_addr.push_back(app_addr);
          resp_due.push_back(cyc + lat);
          void'(exp_cmd.pop_front());
          n_acc++;
        end
      end
      if (exp_wa.size() == 0) chk("bb_wr_en_unexpected", bb_wr_en, 0);
      else if (bb_wr_en) begin
        chk("bb_wr_addr", bb_wr_addr, exp_wa[0]);
        chk("bb_wr_data", bb_wr_data, exp_wd[0]);
        obs_wa.push_back(bb_wr_addr);
        obs_wd.push_back(bb_wr_data);
        void'(exp_wa.pop_front());
        void'(exp_wd.pop_front());
        n_wr++;
      end
    end
  end

  task automatic model_job(input int num, input logic [31:0] ddr, input logic [6:0] bb);
    logic [31:0]  base;
    logic [511:0] beat;
    int           nbeats;
    base   = ddr & ~32'h3F;
    nbeats = (num * 16 + 63) / 64;
    obs_cmd.delete();
    obs_wa.delete();
    obs_wd.delete();
    n_acc = 0;
    n_wr  = 0;
    for (int k = 0; k < nbeats; k++) exp_cmd.push_back(base + 32'(k) * 32'd64);
    for (int i = 0; i < num; i++) begin
      beat = beat_data(base + 32'(i / 4) * 32'd64);
      exp_wa.push_back(7'(32'(bb) + 32'(i)));
      exp_wd.push_back(beat[(i % 4) * 128 +: 128]);
    end
  endtask

  task automatic start_job(input int num, input logic [31:0] ddr, input logic [6:0] bb);
    @(posedge clk);
    #1;
    bfc_conf          = 1'b1;
    bfc_bias_num      = 24'(num);
    bfc_bias_ddr_byte = 24'(num * 16);
    bfc_ddr_st_addr   = ddr;
    bfc_bb_st_addr    = bb;
    @(posedge clk);
    #1;
    bfc_conf = 1'b0;
    #1;
  endtask

  task automatic drain;
    for (int n = 0; n < 400 && resp_due.size() > 0; n++) @(posedge clk);
    chk("stale_returns_drained", resp_due.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic run_job(input int num, input logic [31:0] ddr, input logic [6:0] bb,
                         input int pct, input int l, input bit midconf, input logic [31:0] seed);
    int n;
    drain();
    data_seed = seed;
    rdy_pct   = pct;
    lat       = l;
    model_job(num, ddr, bb);
    start_job(num, ddr, bb);
    if (num == 0) begin
      chk("zero_idle_c1", bfc_idle, 0);
      @(posedge clk); #2;
      chk("zero_idle_c2", bfc_idle, 0);
      @(posedge clk); #2;
      chk("zero_idle_c3", bfc_idle, 1);
    end else begin
      for (n = 0; n < 3000 && exp_wa.size() > 0; n++) begin
        if (midconf && n == 4) begin
          bfc_conf          = 1'b1;
          bfc_bias_num      = 24'd3;
          bfc_bias_ddr_byte = 24'd48;
          bfc_ddr_st_addr   = 32'hDEAD_0000;
          bfc_bb_st_addr    = 7'h55;
        end
        if (n == 5) bfc_conf = 1'b0;
        @(posedge clk);
        #2;
      end
      bfc_conf = 1'b0;
      chk("job_writes_left", exp_wa.size(), 0);
      chk("idle_low_after_last_wr", bfc_idle, 0);
      @(posedge clk); #2;
      chk("idle_high_2_after_last_wr", bfc_idle, 1);
    end
    chk("write_count", obs_wa.size(), num);
    chk("cmds_left", exp_cmd.size(), 0);
  endtask

  initial begin
    rst_n             = 1'b0;
    bfc_conf          = 1'b0;
    bfc_bias_num      = '0;
    bfc_bias_ddr_byte = '0;
    bfc_ddr_st_addr   = '0;
    bfc_bb_st_addr    = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_idle", bfc_idle, 1);
    chk("rst_app_en", app_en, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_bb_wr_en", bb_wr_en, 0);
    chk("rst_bb_wr_addr", bb_wr_addr, 0);
    chk("rst_bb_wr_data", bb_wr_data, 0);
    rst_n = 1'b1;

    // Basic two-beat job, pinned with literals.
    run_job(8, 32'h1000, 7'h10, 100, 2, 1'b0, 32'h0);
    chk("j1_cmd_count", obs_cmd.size(), 2);
    if (obs_cmd.size() == 2) begin
      chk("j1_cmd0", obs_cmd[0], 32'h1000);
      chk("j1_cmd1", obs_cmd[1], 32'h1040);
    end
    if (obs_wa.size() == 8) begin
      chk("j1_wa0", obs_wa[0], 7'h10);
      chk("j1_wa7", obs_wa[7], 7'h17);
      chk("j1_wd1", obs_wd[1], 128'h07071707_06061606_05051505_04041404);
    end

    // Partial last beat.
    run_job(5, 32'h0000_2000, 7'h00, 100, 3, 1'b0, 32'h1234_5678);
    chk("j2_cmd_count", obs_cmd.size(), 2);

    // Credit limit, slow DDR, wrapping buffer address.
    run_job(40, 32'h0008_0000, 7'h7C, 50, 20, 1'b0, 32'hA5A5_0F0F);
    chk("j3_cmd_count", obs_cmd.size(), 10);
    if (obs_wa.size() == 40) begin
      chk("j3_wa3", obs_wa[3], 7'h7F);
      chk("j3_wa4", obs_wa[4], 7'h00);
      chk("j3_wa39", obs_wa[39], 7'h23);
    end

    // Conf pulse during a job is ignored.
    run_job(12, 32'h0000_2345, 7'h30, 70, 5, 1'b1, 32'h0BAD_F00D);

    // Empty job.
    run_job(0, 32'h0000_3000, 7'h01, 100, 2, 1'b0, 32'h0);

    // Reset mid-job, then stale beats arrive.
    drain();
    data_seed = 32'h7777_0000;
    rdy_pct = 100;
    lat = 3;
    model_job(8, 32'h0000_4000, 7'h05);
    start_job(8, 32'h0000_4000, 7'h05);
    for (int n = 0; n < 200 && n_wr < 2; n++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_job_reached_2_writes", n_wr, 2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cmd.delete();
    exp_wa.delete();
    exp_wd.delete();
    resp_addr.push_back(32'h0000_4000);
    resp_due.push_back(cyc + 1);
    resp_addr.push_back(32'h0000_4040);
    resp_due.push_back(cyc + 2);
    chk("midrst_idle", bfc_idle, 1);
    chk("midrst_app_en", app_en, 0);
    chk("midrst_app_addr", app_addr, 0);
    chk("midrst_bb_wr_en", bb_wr_en, 0);
    chk("midrst_bb_wr_addr", bb_wr_addr, 0);
    chk("midrst_bb_wr_data", bb_wr_data, 0);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #2;
      chk("stale_idle", bfc_idle, 1);
    end

    // Recovery and randomized jobs.
    for (int r = 0; r < 8; r++) begin
      run_job($urandom_range(1, 40), $urandom, 7'($urandom), $urandom_range(30, 100),
              $urandom_range(1, 12), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
